// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: word width, NOP encoding and the response record
// carried from the memory read stage through the response FIFO.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response FIFO. A push and a pop can both happen in one cycle,
// even when full; flush empties it and overrides any push or pop that cycle.
module resp_fifo2
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_t       push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output rsp_t       head
);

  rsp_t       entry_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) entry_q[wr_ptr_q] <= push_data;
  end

  assign head  = entry_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: word-addressed instruction RAM with a synchronous
// read, one-deep read stage and a 2-entry in-order response FIFO.
module instr_fetch_responder
  import mips_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic             flush,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic             err_q;
  logic             in_flight_q, in_flight_d;
  logic             accept, addr_fault, pop;
  logic [1:0]       fifo_count;
  rsp_t             push_rsp, head_rsp;

  // Credit check uses registered occupancy only, so rsp_ready never reaches req_ready.
  assign req_ready  = !rst && !flush && (({1'b0, in_flight_q} + fifo_count) < 2'd2);
  assign accept     = req_valid && req_ready;
  assign addr_fault = (req_addr[1:0] != 2'b00) || (req_addr[WIDTH-1:2+AW] != '0);

  // Read-first RAM: a same-edge load to the word being fetched returns old data.
  always_ff @(posedge clk) begin
    if (ld_en)  mem[ld_addr] <= ld_data;
    if (accept) rd_data_q    <= mem[req_addr[2 +: AW]];
  end

  always_ff @(posedge clk) begin
    if (accept) err_q <= addr_fault;
  end

  assign in_flight_d = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_flight_q <= 1'b0;
    else     in_flight_q <= in_flight_d;
  end

  always_comb begin
    push_rsp      = '0;
    push_rsp.data = err_q ? INSTR_NOP : rd_data_q;
    push_rsp.err  = err_q;
  end

  assign pop = rsp_valid && rsp_ready;

  resp_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (push_rsp),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head      (head_rsp)
  );

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_data  = rsp_valid ? head_rsp.data : '0;
  assign rsp_err   = rsp_valid && head_rsp.err;

endmodule
